// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage with a small PC-tagged FIFO.
// Drives the instruction-memory address from fetch_pc, captures the
// combinationally returned instruction, queues {pc, instr} entries and
// presents the head to the decode stage with a valid/ready handshake.
// A redirect flushes the queue and restarts fetching at redirect_pc.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 8,
  parameter int unsigned IW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [AW-1:0]              imem_addr,
  input  logic [IW-1:0]              imem_instr,
  input  logic                       halt,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic [IW-1:0]              ir,
  output logic [AW-1:0]              ir_pc,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Architectural state
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage; contents are qualified by count, so no reset is needed
  logic [AW-1:0] pc_mem_q    [DEPTH];
  logic [IW-1:0] instr_mem_q [DEPTH];

  logic push_s;
  logic pop_s;
  logic valid_s;

  assign valid_s = (count_q != {CW{1'b0}});

  // A redirect suppresses both queue operations; a full queue still
  // accepts a push when the head leaves in the same cycle.
  assign pop_s  = valid_s & ir_ready & ~redirect;
  assign push_s = ~halt & ~redirect & ((count_q < DEPTH_C) | pop_s);

  // Next-state computation for fetch PC, pointers and occupancy count
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + AW'(1);
      end else begin
        wr_ptr_d   = wr_ptr_q;
        fetch_pc_d = fetch_pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Capture the fetched instruction and its PC into the tail entry
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

  // Head presentation is combinational so a fetch is visible one cycle later
  always_comb begin
    if (valid_s) begin
      ir    = instr_mem_q[rd_ptr_q];
      ir_pc = pc_mem_q[rd_ptr_q];
    end else begin
      ir    = {IW{1'b0}};
      ir_pc = {AW{1'b0}};
    end
  end

  assign ir_valid  = valid_s;
  assign occupancy = count_q;
  assign imem_addr = fetch_pc_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: table-driven vectors, a scoreboard
// queue of expected {pc, instr} entries, and hand-written corner sequences.
module tb_ifetch_queue;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        halt;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [2:0]  occupancy;

  int n_pass;
  int n_total;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] exp_pc;

  typedef struct packed {
    logic        h;
    logic        r;
    logic [7:0]  rpc;
    logic        rdy;
    logic [2:0]  occ;
    logic [7:0]  addr;
    logic        v;
    logic [15:0] ir;
    logic [7:0]  pc;
  } vec_t;

  vec_t tbl[10];

  ifetch_queue #(.DEPTH(4), .AW(8), .IW(16), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .halt       (halt),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .occupancy  (occupancy)
  );

  // Instruction memory model: IMEM[n] = 0x1000 + n
  function automatic logic [15:0] imem(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  assign imem_instr = imem(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle: compare outputs against the scoreboard before the edge,
  // update the scoreboard with the expected push/pop, then take the edge.
  task automatic apply(input logic h, input logic r, input logic [7:0] rpc, input logic rdy);
    logic do_pop;
    logic do_push;
    halt        = h;
    redirect    = r;
    redirect_pc = rpc;
    ir_ready    = rdy;
    #3;
    chk("sb_valid", {31'd0, ir_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
    chk("sb_occ", {29'd0, occupancy}, 32'(exp_q.size()));
    chk("sb_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    if (exp_q.size() != 0) begin
      chk("sb_ir", {16'd0, ir}, {16'd0, exp_q[0].instr});
      chk("sb_ir_pc", {24'd0, ir_pc}, {24'd0, exp_q[0].pc});
    end else begin
      chk("sb_ir_empty", {16'd0, ir}, 32'd0);
      chk("sb_ir_pc_empty", {24'd0, ir_pc}, 32'd0);
    end
    do_pop  = (exp_q.size() != 0) && rdy && !r;
    do_push = !h && !r && ((exp_q.size() < 4) || do_pop);
    if (r) begin
      exp_q.delete();
      exp_pc = rpc;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({exp_pc, imem(exp_pc)});
        exp_pc = exp_pc + 8'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wrap_exp[4];
  int         found;

  initial begin
    n_pass      = 0;
    n_total     = 0;
    reset       = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    ir_ready    = 1'b0;
    exp_pc      = 8'h00;

    // Vectors: {halt, redirect, rpc, ready, occ, addr, valid, ir, ir_pc} after the edge
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 8'h01, 1'b1, 16'h1000, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h02, 1'b1, 16'h1000, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 8'h03, 1'b1, 16'h1000, 8'h00};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 8'h04, 1'b1, 16'h1000, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 8'h04, 1'b1, 16'h1000, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 8'h05, 1'b1, 16'h1001, 8'h01};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 8'h06, 1'b1, 16'h1002, 8'h02};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 8'h07, 1'b1, 16'h1003, 8'h03};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 8'h07, 1'b1, 16'h1003, 8'h03};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd4, 8'h07, 1'b1, 16'h1003, 8'h03};

    // Reset state
    #2;
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_ir_pc", {24'd0, ir_pc}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fill with ready low, then stream from a full queue, then hold/halt stable
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].h, tbl[i].r, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d_occ", i), {29'd0, occupancy}, {29'd0, tbl[i].occ});
      chk($sformatf("tbl%0d_addr", i), {24'd0, imem_addr}, {24'd0, tbl[i].addr});
      chk($sformatf("tbl%0d_valid", i), {31'd0, ir_valid}, {31'd0, tbl[i].v});
      chk($sformatf("tbl%0d_ir", i), {16'd0, ir}, {16'd0, tbl[i].ir});
      chk($sformatf("tbl%0d_ir_pc", i), {24'd0, ir_pc}, {24'd0, tbl[i].pc});
    end

    // Redirect while streaming: restart from 0, stream until head pc is 5
    apply(1'b0, 1'b1, 8'h00, 1'b0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (found == 0) begin
        if (ir_valid === 1'b1 && ir_pc === 8'h05) begin
          found = 1;
        end else begin
          apply(1'b0, 1'b0, 8'h00, 1'b1);
          chk("stream_occ", {29'd0, occupancy}, 32'd1);
        end
      end
    end
    chk("reach_pc5", found, 32'd1);
    apply(1'b0, 1'b1, 8'h40, 1'b1);
    chk("redir_valid", {31'd0, ir_valid}, 32'd0);
    chk("redir_addr", {24'd0, imem_addr}, 32'h40);
    chk("redir_occ", {29'd0, occupancy}, 32'd0);
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    chk("redir_ir", {16'd0, ir}, 32'h1040);
    chk("redir_ir_pc", {24'd0, ir_pc}, 32'h40);

    // PC wrap from 0xFE through 0x01
    wrap_exp[0] = 8'hFE;
    wrap_exp[1] = 8'hFF;
    wrap_exp[2] = 8'h00;
    wrap_exp[3] = 8'h01;
    apply(1'b0, 1'b1, 8'hFE, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1);
      chk($sformatf("wrap%0d_pc", i), {24'd0, ir_pc}, {24'd0, wrap_exp[i]});
      chk($sformatf("wrap%0d_occ", i), {29'd0, occupancy}, 32'd1);
    end

    // Halt drain: fill from 0x10, then drain 4 with halt held
    apply(1'b0, 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 8'h00, 1'b0);
    chk("halt_full_occ", {29'd0, occupancy}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("halt%0d_addr", i), {24'd0, imem_addr}, 32'h14);
    end
    chk("halt_empty", {31'd0, ir_valid}, 32'd0);
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    chk("resume_pc", {24'd0, ir_pc}, 32'h14);
    chk("resume_ir", {16'd0, ir}, 32'h1014);
    // Redirect while halted still loads the PC and flushes
    apply(1'b1, 1'b1, 8'h80, 1'b0);
    chk("halt_redir_addr", {24'd0, imem_addr}, 32'h80);
    chk("halt_redir_occ", {29'd0, occupancy}, 32'd0);

    // Asynchronous reset mid-period with three entries queued
    apply(1'b0, 1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_arst_occ", {29'd0, occupancy}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ir_valid}, 32'd0);
    chk("arst_occ", {29'd0, occupancy}, 32'd0);
    chk("arst_ir", {16'd0, ir}, 32'd0);
    chk("arst_addr", {24'd0, imem_addr}, 32'd0);
    exp_q.delete();
    exp_pc = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    chk("post_arst_ir", {16'd0, ir}, 32'h1000);
    chk("post_arst_occ", {29'd0, occupancy}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
